// File: rtl/reg_bank_rr_write_arbiter.sv
// reg_bank_rr_write_arbiter
//  Round-robin arbiter that lets NREQ requesters share one bank of NREG
//  enabled registers. Each grant performs exactly one write. The bank is read
//  combinationally.
//  Optional feature macro: REG_WRITE_PROTECT_EN adds the wp_mask input and the
//  wr_err output. A write to a protected register is dropped and flagged.
module reg_bank_rr_write_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREG  = 4,
  parameter int unsigned AW    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*AW-1:0]     req_addr,
  input  logic [NREQ*WIDTH-1:0]  req_data,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
`ifdef REG_WRITE_PROTECT_EN
  input  logic [NREG-1:0]        wp_mask,
  output logic                   wr_err,
`endif
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     winner_q, winner_d;
  logic [AW-1:0]     stage_addr_q, stage_addr_d;
  logic [WIDTH-1:0]  stage_data_q, stage_data_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  bank_q [NREG];

  logic              found;
  logic [PW-1:0]     win;
  logic              wp_hit;
  logic [NREG-1:0]   bank_en;

  // Round-robin search starting at ptr_q and wrapping past NREQ-1.
  always_comb begin : arb_search
    int unsigned idx;
    logic [PW-1:0] idx_w;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_w = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = PW'(idx);
      if (!found && req[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
  end

`ifdef REG_WRITE_PROTECT_EN
  // Protection bit of the staged address, sampled live during WRITE.
  always_comb begin
    wp_hit = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (stage_addr_q == AW'(i)) wp_hit = wp_mask[i];
    end
  end

  assign wr_err = (state_q == WRITE) && wp_hit;
`else
  assign wp_hit = 1'b0;
`endif

  // One-hot bank enable; out-of-range addresses match no register.
  always_comb begin
    bank_en = '0;
    if (state_q == WRITE && !wp_hit) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (stage_addr_q == AW'(i)) bank_en[i] = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/WRITE FSM.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    winner_d     = winner_q;
    stage_addr_d = stage_addr_q;
    stage_data_d = stage_data_q;
    gnt_d        = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          winner_d     = win;
          stage_addr_d = req_addr[32'(win) * AW +: AW];
          stage_data_d = req_data[32'(win) * WIDTH +: WIDTH];
          gnt_d        = NREQ'(1) << win;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        ptr_d   = (winner_q == PW'(NREQ - 1)) ? '0 : PW'(winner_q + PW'(1));
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == WRITE);
  end

  // Control and staging registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      winner_q     <= '0;
      stage_addr_q <= '0;
      stage_data_q <= '0;
      gnt_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      winner_q     <= winner_d;
      stage_addr_q <= stage_addr_d;
      stage_data_q <= stage_data_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
    end
  end

  // Shared register bank: async-reset flops with enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) bank_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (bank_en[i]) bank_q[i] <= stage_data_q;
      end
    end
  end

  // Combinational read port; unmapped addresses read as zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (rd_addr == AW'(i)) rd_data = bank_q[i];
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_reg_bank_rr_write_arbiter.sv
// Directed testbench for reg_bank_rr_write_arbiter (4 requesters, 4x4-bit bank).
module tb_reg_bank_rr_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  req_addr;
  logic [15:0] req_data;
  logic [3:0]  gnt;
  logic        busy;
  logic [1:0]  rd_addr;
  logic [3:0]  rd_data;
`ifdef REG_WRITE_PROTECT_EN
  logic [3:0]  wp_mask;
  logic        wr_err;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  reg_bank_rr_write_arbiter #(.NREQ(4), .WIDTH(4), .NREG(4), .AW(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .busy     (busy),
`ifdef REG_WRITE_PROTECT_EN
    .wp_mask  (wp_mask),
    .wr_err   (wr_err),
`endif
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Advance one clock and settle 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] a, input logic [3:0] d);
    req_addr[i*2 +: 2] = a;
    req_data[i*4 +: 4] = d;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req   = '0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = '0;
    tick();
    tick();
    total_cnt++;
    if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected %b", busy, 1'b0);
    else pass_cnt++;
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      total_cnt++;
      if (rd_data !== 4'h0) $display("FAIL reset_bank%0d: got %h expected %h", a, rd_data, 4'h0);
      else pass_cnt++;
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    set_req(0, 2'd2, 4'hA);
    rd_addr = 2'd2;
    req = 4'b0001;
    tick();
    total_cnt++;
    if (gnt !== 4'b0001) $display("FAIL t2_gnt: got %b expected %b", gnt, 4'b0001);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL t2_busy: got %b expected %b", busy, 1'b1);
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== 4'h0) $display("FAIL t2_old_data: got %h expected %h", rd_data, 4'h0);
    else pass_cnt++;
    req = 4'b0000;
    tick();
    total_cnt++;
    if (gnt !== 4'b0000) $display("FAIL t2_gnt_drop: got %b expected %b", gnt, 4'b0000);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL t2_busy_drop: got %b expected %b", busy, 1'b0);
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== 4'hA) $display("FAIL t2_rd: got %h expected %h", rd_data, 4'hA);
    else pass_cnt++;
  endtask

  // Reset mid-run (pointer is 1 here): bank clears and arbitration restarts at 0.
  task automatic test_reset_midrun();
    reset = 1'b0;
    rd_addr = 2'd2;
    #1;
    total_cnt++;
    if (rd_data !== 4'h0) $display("FAIL t1_bank2_cleared: got %h expected %h", rd_data, 4'h0);
    else pass_cnt++;
    tick();
    reset = 1'b1;
    tick();
    set_req(0, 2'd0, 4'h6);
    set_req(3, 2'd1, 4'h7);
    req = 4'b1001;
    tick();
    total_cnt++;
    if (gnt !== 4'b0001) $display("FAIL t1_ptr_restart: got %b expected %b", gnt, 4'b0001);
    else pass_cnt++;
    req = 4'b0000;
    tick();
    rd_addr = 2'd0;
    #1;
    total_cnt++;
    if (rd_data !== 4'h6) $display("FAIL t1_write0: got %h expected %h", rd_data, 4'h6);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 4'(i + 1));
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      exp_gnt = 4'b0001 << i;
      tick();
      total_cnt++;
      if (gnt !== exp_gnt) $display("FAIL t3_gnt%0d: got %b expected %b", i, gnt, exp_gnt);
      else pass_cnt++;
      req[i] = 1'b0;
      tick();
      total_cnt++;
      if (gnt !== 4'b0000) $display("FAIL t3_gap%0d: got %b expected %b", i, gnt, 4'b0000);
      else pass_cnt++;
    end
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      total_cnt++;
      if (rd_data !== 4'(a + 1)) $display("FAIL t3_bank%0d: got %h expected %h", a, rd_data, 4'(a + 1));
      else pass_cnt++;
    end
    // Grant requester 1 alone, then 0 and 2 together: 2 must win first.
    req = 4'b0010;
    tick();
    total_cnt++;
    if (gnt !== 4'b0010) $display("FAIL t3_g1: got %b expected %b", gnt, 4'b0010);
    else pass_cnt++;
    req = 4'b0000;
    tick();
    req = 4'b0101;
    tick();
    total_cnt++;
    if (gnt !== 4'b0100) $display("FAIL t3_after1: got %b expected %b", gnt, 4'b0100);
    else pass_cnt++;
    req = 4'b0001;
    tick();
    tick();
    total_cnt++;
    if (gnt !== 4'b0001) $display("FAIL t3_then0: got %b expected %b", gnt, 4'b0001);
    else pass_cnt++;
    req = 4'b0000;
    tick();
  endtask

  task automatic test_collision();
    apply_reset();
    set_req(0, 2'd1, 4'h5);
    set_req(1, 2'd1, 4'h9);
    rd_addr = 2'd1;
    req = 4'b0011;
    tick();
    total_cnt++;
    if (gnt !== 4'b0001) $display("FAIL t4_first: got %b expected %b", gnt, 4'b0001);
    else pass_cnt++;
    req[0] = 1'b0;
    set_req(0, 2'd1, 4'hE);
    tick();
    total_cnt++;
    if (rd_data !== 4'h5) $display("FAIL t4_captured: got %h expected %h", rd_data, 4'h5);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (gnt !== 4'b0010) $display("FAIL t4_second: got %b expected %b", gnt, 4'b0010);
    else pass_cnt++;
    req = 4'b0000;
    tick();
    total_cnt++;
    if (rd_data !== 4'h9) $display("FAIL t4_final: got %h expected %h", rd_data, 4'h9);
    else pass_cnt++;
  endtask

  // Pointer is 2 here; a surviving pointer would pick requester 2, not 1.
  task automatic test_reset_mid_write();
    set_req(3, 2'd3, 4'hF);
    req = 4'b1000;
    tick();
    total_cnt++;
    if (gnt !== 4'b1000) $display("FAIL t5_gnt: got %b expected %b", gnt, 4'b1000);
    else pass_cnt++;
    #2;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (gnt !== 4'b0000) $display("FAIL t5_gnt_async: got %b expected %b", gnt, 4'b0000);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL t5_busy_async: got %b expected %b", busy, 1'b0);
    else pass_cnt++;
    req = 4'b0000;
    tick();
    reset = 1'b1;
    rd_addr = 2'd3;
    tick();
    total_cnt++;
    if (rd_data !== 4'h0) $display("FAIL t5_bank3: got %h expected %h", rd_data, 4'h0);
    else pass_cnt++;
    set_req(1, 2'd0, 4'h1);
    set_req(2, 2'd0, 4'h2);
    req = 4'b0110;
    tick();
    total_cnt++;
    if (gnt !== 4'b0010) $display("FAIL t5_ptr0: got %b expected %b", gnt, 4'b0010);
    else pass_cnt++;
    req = 4'b0000;
    tick();
  endtask

`ifdef REG_WRITE_PROTECT_EN
  task automatic test_write_protect();
    apply_reset();
    wp_mask = 4'b1000;
    set_req(0, 2'd3, 4'h7);
    req = 4'b0001;
    tick();
    total_cnt++;
    if (gnt !== 4'b0001) $display("FAIL t6_gnt: got %b expected %b", gnt, 4'b0001);
    else pass_cnt++;
    total_cnt++;
    if (wr_err !== 1'b1) $display("FAIL t6_wr_err: got %b expected %b", wr_err, 1'b1);
    else pass_cnt++;
    req = 4'b0000;
    rd_addr = 2'd3;
    tick();
    total_cnt++;
    if (rd_data !== 4'h0) $display("FAIL t6_bank3: got %h expected %h", rd_data, 4'h0);
    else pass_cnt++;
    total_cnt++;
    if (wr_err !== 1'b0) $display("FAIL t6_wr_err_idle: got %b expected %b", wr_err, 1'b0);
    else pass_cnt++;
    set_req(1, 2'd2, 4'h7);
    req = 4'b0010;
    tick();
    total_cnt++;
    if (wr_err !== 1'b0) $display("FAIL t6_wr_ok: got %b expected %b", wr_err, 1'b0);
    else pass_cnt++;
    req = 4'b0000;
    rd_addr = 2'd2;
    tick();
    total_cnt++;
    if (rd_data !== 4'h7) $display("FAIL t6_bank2: got %h expected %h", rd_data, 4'h7);
    else pass_cnt++;
  endtask
`endif

  initial begin
    reset    = 1'b0;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    rd_addr  = '0;
`ifdef REG_WRITE_PROTECT_EN
    wp_mask  = '0;
`endif
    test_reset();
    test_single_write();
    test_reset_midrun();
    apply_reset();
    test_round_robin();
    test_collision();
    test_reset_mid_write();
`ifdef REG_WRITE_PROTECT_EN
    test_write_protect();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
